matrix_store_unit: RTL and testbench
====================================

# matrix_store_unit

Consumer for the 128-bit matrix accumulator produced by the execute-stage MOPA operation. It captures one 4x4 int8 matrix and a base address, then serialises the matrix into four 32-bit row writes on the data-memory write port. Memory back-pressure is handled with a valid/ready-style stall. It sits between the EX/MEM pipeline register and the data-memory write mux, and is the store path for matrix results.

## Interface
- `ROW_STRIDE`, default 4: byte distance between consecutive row addresses. Must be a multiple of 4.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `req_valid`  in  1: store request present.
- `req_ready`  out  1: unit can accept a request.
- `req_matrix`  in  128: matrix. Row i = bits [i*32+31 : i*32]. Element (i,j) = bits [i*32+j*8+7 : i*32+j*8].
- `req_addr`  in  32: byte base address of row 0.
- `mem_we`  out  1: write beat valid.
- `mem_ready`  in  1: memory accepts the beat this cycle.
- `mem_addr`  out  32: beat byte address.
- `mem_wdata`  out  32: beat data (row word, element j in byte lane j).
- `busy`  out  1: request in progress.
- `done`  out  1: one-cycle pulse after the last beat is accepted.
- `err`  out  1: one-cycle pulse when a misaligned request is rejected.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - STORE: `busy`=1, `mem_we`=1.
  - FIN: `done`=1.
- Handshake: a request is accepted when `req_valid && req_ready`. On accept, `req_matrix` and `req_addr` are latched into internal registers. Inputs are ignored at all other times.
- IDLE transitions on accept:
  - `req_addr[1:0]==0`: go to STORE, with row counter `row`=0 and `mem_addr`=`req_addr`.
  - `req_addr[1:0]!=0`: no beats are issued. `err` pulses in the next cycle and the unit stays in IDLE.
- In STORE:
  - `mem_wdata` = latched row `row`.
  - `mem_addr` = base + `row`*`ROW_STRIDE`, modulo 2^32. Wrap past 0xFFFFFFFF is silent.
- A beat completes when `mem_we && mem_ready`. On completion `row` increments.
- If `mem_ready`=0, `mem_addr` and `mem_wdata` hold exactly, with no limit on stall length.
- When the beat with `row`=3 completes, go to FIN.
- FIN always goes to IDLE after one cycle.
- `mem_addr` and `mem_wdata` are 0 whenever `mem_we`=0.
- Reset values, held while `rst`=1: state IDLE, `row`=0, `req_ready`=0, and `mem_we`, `mem_addr`, `mem_wdata`, `busy`, `done`, `err` all 0. `req_ready` rises in the first cycle after `rst` deasserts.
- Reset mid-STORE: state goes to IDLE at that edge. No further beats are issued and `done` does not pulse. A partial store is abandoned.
- A beat accepted in the same cycle that `rst`=1 is not counted.

## Timing
- All outputs are registered, or decoded only from state registers. There are no combinational input-to-output paths.
- Accept at edge T:
  - beats are presented from cycle T+1;
  - with `mem_ready` tied high, beats occupy T+1..T+4;
  - `done`=1 in T+5;
  - `req_ready`=1 in T+6.
- Minimum request-to-request spacing is 6 cycles. Each stall cycle adds one cycle.
- Misaligned accept at T: `err`=1 in T+1 and `req_ready` stays 1. Throughput for rejected requests is one per cycle.
- `done` and `err` are never asserted together.

## Test plan
- Aligned store, `mem_ready`=1:
  - stimulus: `req_addr`=0x1000, `req_matrix`=0x0F0E0D0C_0B0A0908_07060504_03020100.
  - required: beats (0x1000, 0x03020100), (0x1004, 0x07060504), (0x1008, 0x0B0A0908), (0x100C, 0x0F0E0D0C) on 4 consecutive cycles; `done` in T+5.
- Back-pressure:
  - stimulus: same request, `mem_ready` low on cycles 2 and 3 of row 1.
  - required: address 0x1004 and data 0x07060504 hold for 3 cycles; `done` in T+7; no duplicate or skipped rows.
- Wrap:
  - stimulus: `req_addr`=0xFFFFFFF8.
  - required: beat addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Misaligned:
  - stimulus: `req_addr`=0x1002.
  - required: zero beats, `err`=1 for exactly one cycle, `busy` stays 0.
- Reset mid-op:
  - stimulus: assert `rst` after the row-1 beat completes.
  - required: `mem_we`=0 from the next cycle, no `done`; a fresh request after reset stores all 4 rows from row 0.
- Back-to-back:
  - stimulus: `req_valid` held high with two requests.
  - required: second request accepted exactly when `req_ready` returns (T+6); `req_ready`=0 throughout STORE and FIN.

Source files
------------

// File: rtl/matrix_store_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// matrix_store_unit
//
// Store path for the 4x4 int8 matrix accumulator produced by the MOPA
// execute stage. A request carries one 128-bit matrix and a byte base
// address. The unit latches both and serialises the matrix into four 32-bit
// row writes on the data-memory write port, one row per accepted beat.
// Memory back-pressure stalls the current beat for as long as mem_ready is
// low. A request whose base address is not word aligned is rejected with a
// one-cycle err pulse and no beats.
//
// Parameters
//   ROW_STRIDE  byte distance between consecutive row addresses (multiple of 4)
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous reset, active high
//   req_valid   store request present
//   req_ready   unit can accept a request (IDLE, registered)
//   req_matrix  matrix, row i = bits [i*32+31 : i*32], element j in byte j
//   req_addr    byte base address of row 0
//   mem_we      write beat valid
//   mem_ready   memory accepts the beat this cycle
//   mem_addr    beat byte address (0 when mem_we is low)
//   mem_wdata   beat data, one matrix row (0 when mem_we is low)
//   busy        request in progress
//   done        one-cycle pulse after the last beat is accepted
//   err         one-cycle pulse after a misaligned request is rejected
// ---------------------------------------------------------------------------
module matrix_store_unit #(
  parameter int ROW_STRIDE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [127:0] req_matrix,
  input  logic [31:0]  req_addr,
  output logic         mem_we,
  input  logic         mem_ready,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    FIN   = 2'd2
  } state_t;

  localparam logic [31:0] STRIDE = 32'(ROW_STRIDE);

  state_t        state;
  state_t        state_next;
  logic [127:0]  matrix_q;
  logic [31:0]   addr_q;
  logic [1:0]    row_q;
  logic          ready_q;
  logic          err_q;
  logic          accept;
  logic          aligned;
  logic          beat_done;

  // ready_q is only ever high while the FSM sits in IDLE, so an accept can
  // only happen from IDLE and needs no separate state qualifier.
  assign accept    = req_valid && ready_q;
  assign aligned   = (req_addr[1:0] == 2'b00);
  assign beat_done = (state == STORE) && mem_ready;

  // State register; reset wins over any beat completing in the same cycle,
  // which is what abandons a partial store without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and output decode. Beat address and data come straight
  // from the latched registers, so they hold exactly during a stall and are
  // forced to zero outside STORE.
  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (accept && aligned) begin
          state_next = STORE;
        end
      end
      STORE: begin
        mem_we    = 1'b1;
        busy      = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = matrix_q[{row_q, 5'b00000} +: 32];
        if (beat_done && (row_q == 2'd3)) begin
          state_next = FIN;
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign req_ready = ready_q;
  assign err       = err_q;

  // Datapath registers. addr_q advances by the stride on every completed
  // beat so the address is a plain register output; 32-bit arithmetic gives
  // the silent wrap past 0xFFFFFFFF. ready_q tracks the upcoming state so it
  // stays low through reset and rises one cycle after reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      matrix_q <= 128'd0;
      addr_q   <= 32'd0;
      row_q    <= 2'd0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ready_q <= (state_next == IDLE);
      err_q   <= accept && !aligned;
      if (accept) begin
        matrix_q <= req_matrix;
        addr_q   <= req_addr;
        row_q    <= 2'd0;
      end else if (beat_done) begin
        row_q  <= row_q + 2'd1;
        addr_q <= addr_q + STRIDE;
      end
    end
  end

endmodule

// File: tb/tb_matrix_store_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_matrix_store_unit
//
// Scoreboard bench for matrix_store_unit. Each accepted aligned request pushes
// its four expected (address, row) beats; a negedge monitor pops and compares
// every completed beat, checks that stalled beats hold, that address/data are
// zero outside beats, and that done and err never coincide.
// ---------------------------------------------------------------------------
module tb_matrix_store_unit;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [127:0] req_matrix = 128'd0;
  logic [31:0]  req_addr = 32'd0;
  logic         mem_we;
  logic         mem_ready = 1'b1;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         busy;
  logic         done;
  logic         err;

  int           checks = 0;
  int           fails = 0;
  int           cyc = 0;
  int           acc_cyc = 0;
  int           done_count = 0;
  int           err_count = 0;
  logic [63:0]  sb[$];

  localparam logic [127:0] MAT_A = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] MAT_B = 128'h8F8E8D8C_4B4A4948_27262524_F3F2F1F0;

  matrix_store_unit #(.ROW_STRIDE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_matrix (req_matrix),
    .req_addr   (req_addr),
    .mem_we     (mem_we),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Edge counter used to time events relative to the accept edge
  always @(posedge clk) cyc <= cyc + 1;

  // Global time limit so a stuck DUT still ends the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Count one comparison and report a mismatch
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Beat monitor / scoreboard consumer, sampled mid-cycle
  initial begin
    bit          stalled_prev;
    logic [63:0] held;
    stalled_prev = 1'b0;
    held = 64'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled_prev = 1'b0;
      end else begin
        if (done) done_count++;
        if (err) err_count++;
        checkOutput("done_err_excl", {63'd0, done & err}, 64'd0);
        if (mem_we) begin
          if (stalled_prev) checkOutput("stall_hold", {mem_addr, mem_wdata}, held);
          if (!mem_ready) begin
            stalled_prev = 1'b1;
            held = {mem_addr, mem_wdata};
          end else begin
            stalled_prev = 1'b0;
            if (sb.size() == 0) checkOutput("unexpected_beat", 64'd1, 64'd0);
            else checkOutput("beat", {mem_addr, mem_wdata}, sb.pop_front());
          end
        end else begin
          stalled_prev = 1'b0;
          checkOutput("idle_zero", {mem_addr, mem_wdata}, 64'd0);
        end
      end
    end
  end

  // Present a request, wait (bounded) for it to be accepted, record the accept
  // edge and push the expected beats for an aligned address.
  task automatic applyStimulus(input logic [31:0] addr, input logic [127:0] mat);
    bit seen;
    seen = 1'b0;
    req_valid  = 1'b1;
    req_addr   = addr;
    req_matrix = mat;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checkOutput("accept_timeout", 64'd0, 64'd1);
    end else begin
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      if (addr[1:0] == 2'b00) begin
        for (int i = 0; i < 4; i++) begin
          logic [31:0] a;
          a = addr + 32'(i * 4);
          sb.push_back({a, mat[i*32 +: 32]});
        end
      end
    end
    req_valid = 1'b0;
  endtask

  // Run an accepted store to completion, stalling mem_ready for relative
  // cycles stall_lo..stall_hi, and check the done cycle and req_ready return.
  task automatic runStore(input int stall_lo, input int stall_hi, input int done_delta);
    bit got;
    int rel;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      rel = cyc - acc_cyc;
      mem_ready = !(rel >= stall_lo && rel <= stall_hi);
      @(negedge clk);
      checkOutput("ready_low", {63'd0, req_ready}, 64'd0);
      if (done) begin
        got = 1'b1;
        checkOutput("done_cycle", 64'(cyc - acc_cyc), 64'(done_delta));
        checkOutput("busy_fin", {63'd0, busy}, 64'd0);
      end else begin
        checkOutput("busy_high", {63'd0, busy}, 64'd1);
      end
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    if (!got) checkOutput("done_timeout", 64'd0, 64'd1);
    else checkOutput("ready_return", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    int prev_acc;
    int errs_before;
    int dones_before;

    // Reset: every output low while rst is held
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs",
                {25'd0, req_ready, mem_we, busy, done, err, mem_addr},
                64'd0);
    checkOutput("reset_wdata", {32'd0, mem_wdata}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("ready_after_reset", {63'd0, req_ready}, 64'd1);

    // Aligned store, no back-pressure
    $display("[TB] aligned store");
    applyStimulus(32'h0000_1000, MAT_A);
    runStore(1, 0, 4);
    checkOutput("sb_drained_aligned", 64'(sb.size()), 64'd0);

    // Back-pressure: row 1 held for three cycles
    $display("[TB] back-pressure");
    applyStimulus(32'h0000_1000, MAT_A);
    runStore(1, 2, 6);
    checkOutput("sb_drained_stall", 64'(sb.size()), 64'd0);

    // Address wrap past 0xFFFFFFFF
    $display("[TB] wrap");
    applyStimulus(32'hFFFF_FFF8, MAT_B);
    runStore(1, 0, 4);
    checkOutput("sb_drained_wrap", 64'(sb.size()), 64'd0);

    // Misaligned request: single err pulse, no beats, never busy
    $display("[TB] misaligned");
    errs_before = err_count;
    applyStimulus(32'h0000_1002, MAT_B);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("err_pulse", {63'd0, err}, (k == 0) ? 64'd1 : 64'd0);
      checkOutput("misaligned_busy", {62'd0, busy, mem_we}, 64'd0);
      checkOutput("misaligned_ready", {63'd0, req_ready}, 64'd1);
    end
    @(posedge clk);
    #1;
    checkOutput("err_count", 64'(err_count - errs_before), 64'd1);

    // Reset after the row-1 beat completes
    $display("[TB] reset mid-store");
    applyStimulus(32'h0000_2000, MAT_B);
    dones_before = done_count;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_stops_beats", {62'd0, mem_we, busy}, 64'd0);
    checkOutput("abandoned_rows", 64'(sb.size()), 64'd2);
    sb.delete();
    repeat (6) @(posedge clk);
    #1;
    checkOutput("no_done_after_reset", 64'(done_count - dones_before), 64'd0);
    applyStimulus(32'h0000_3000, MAT_A);
    runStore(1, 0, 4);
    checkOutput("sb_drained_fresh", 64'(sb.size()), 64'd0);

    // Back-to-back: second request held valid through the first store
    $display("[TB] back-to-back");
    applyStimulus(32'h0000_4000, MAT_A);
    req_valid  = 1'b1;
    req_addr   = 32'h0000_5000;
    req_matrix = MAT_B;
    runStore(1, 0, 4);
    prev_acc = acc_cyc;
    applyStimulus(32'h0000_5000, MAT_B);
    checkOutput("b2b_spacing", 64'(acc_cyc - prev_acc), 64'd6);
    runStore(1, 0, 4);
    checkOutput("sb_drained_b2b", 64'(sb.size()), 64'd0);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
